pipe_fetch_ctrl: RTL
====================

# pipe_fetch_ctrl

Sequencing controller for the pipelined CPU's instruction-fetch stage. Owns the architectural PC register and drives it from the next-PC value computed by the fetch datapath. Generates the PC and IF/ID instruction-register write enables, and applies boot delay, stall, redirect, halt and fault handling. Keeps saturating performance counters for stalls and redirects. Sits between the ID-stage hazard/branch logic and the fetch datapath (PC mux plus synchronous instruction ROM).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BOOT_CYCLES, 1, cycles held in BOOT after reset so the synchronous ROM output settles (legal 1..15)
- CNT_W, 16, width of the stall and redirect counters

Ports:
- clock  in  1  system clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- npc  in  32  next PC from the fetch datapath mux
- pcsource  in  2  ID-stage PC select: 00 sequential, 01 branch, 10 register jump, 11 jump
- stall  in  1  load-use hazard hold request from ID
- halt  in  1  stop fetching; sticky until reset
- pc  out  32  current fetch PC (registered)
- pc_we  out  1  PC write enable (combinational)
- ir_we  out  1  IF/ID instruction register write enable (combinational)
- fetch_valid  out  1  fetched instruction is valid this cycle
- fault  out  1  sticky misaligned-target fault
- stall_cnt  out  CNT_W  saturating count of stalled RUN cycles
- redirect_cnt  out  CNT_W  saturating count of taken redirects

## Operation
- FSM states: BOOT, RUN, HALT, FAULT.
- Reset (resetn=0 at edge):
  - state=BOOT, pc=RESET_PC, boot counter=BOOT_CYCLES-1, fault=0, both counters=0.
- BOOT:
  - pc_we=ir_we=fetch_valid=0; pc holds.
  - Counter decrements each cycle. At 0 the FSM goes to RUN at the next edge.
  - halt is ignored in BOOT.
- RUN: each cycle is resolved by strict priority halt > stall > fault check > normal update.
  - halt=1: next state HALT; pc holds; pc_we=ir_we=0 this cycle.
  - stall=1: pc_we=ir_we=0; pc holds; stall_cnt++ (saturating). pcsource is ignored and the redirect is not counted; ID re-presents it next cycle.
  - npc[1:0]!=00: next state FAULT, fault<=1, pc holds at the last valid value, pc_we=ir_we=0.
  - Otherwise pc_we=ir_we=fetch_valid=1 and pc<=npc. If pcsource!=00, redirect_cnt++ (saturating). The fetch datapath zeroes the wrong-path instruction itself, so no extra flush is required here.
- HALT:
  - pc_we=ir_we=fetch_valid=0; pc frozen.
  - Exit only via reset. stall and pcsource are ignored.
- FAULT:
  - Same outputs as HALT, with fault=1. Exit only via reset.
- fetch_valid=pc_we=ir_we in RUN. All three are 0 in every other state.
- Counters:
  - Stick at all-ones; never wrap.
  - Frozen outside RUN.
- PC arithmetic: full 32 bits, no masking. Wrap-around from 32'hFFFF_FFFC to 0 via npc is legal. ROM aliasing above its depth is the datapath's concern.

## Timing
- pc is registered: an npc value accepted at edge N appears on pc after edge N.
- pc_we and ir_we are combinational from state, stall, halt and npc[1:0]. There are no registered enables.
- First fetch_valid=1 occurs BOOT_CYCLES cycles after resetn is sampled high.
- Simultaneous events:
  - stall with pcsource!=00: hold, count stall only.
  - halt with stall: HALT entered, stall counted 0.
  - halt with misaligned npc: HALT wins, fault stays 0.
- Reset mid-operation (any state) takes effect at the next edge, with full reset values.

## Structure
- Shared package pipe_pkg holds:
  - state enum (BOOT, RUN, HALT, FAULT)
  - pcsource encodings (PCS_SEQ, PCS_BR, PCS_JR, PCS_J)
  - default RESET_PC
- One sub-module, sat_counter (parameterised width, synchronous active-low clear, increment enable, saturation at max), instantiated twice.
- FSM plus PC register in pipe_fetch_ctrl.

## Test plan
- Reset, BOOT_CYCLES=1, npc=pc+4, no stall → pc reads 0, then 0x4, 0x8, 0xC on successive edges; fetch_valid first high 1 cycle after reset release.
- Branch: at pc=0x10, pcsource=01, npc=0x40 → pc=0x40 next cycle; redirect_cnt=1.
- Stall plus jump: stall=1 and pcsource=11 (npc=0x80) for 2 cycles, then stall=0 → pc holds for 2 cycles then becomes 0x80; stall_cnt=2, redirect_cnt=1.
- Fault: npc=0x22 in RUN → fault=1, pc holds previous value, pc_we=0 thereafter; resetn low for 1 cycle clears fault and pc=RESET_PC.
- Halt: halt pulse at pc=0x100 → pc frozen at 0x100 indefinitely, fetch_valid=0, counters frozen; halt during BOOT has no effect.
- Saturation: CNT_W=4, stall held 20 RUN cycles → stall_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction-fetch sequencing logic.
// Latency: n/a (definitions only). Backpressure: n/a.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Latency: count visible one cycle after inc. Backpressure: none; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, gates PC/IR writes through boot, stall, halt and fault.
// Latency: npc accepted at an edge shows on pc after that edge; enables are combinational.
// Backpressure: stall holds pc and IR in place; halt and fault freeze fetch until reset.
module pipe_fetch_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BOOT_CYCLES = 1,
    parameter int          CNT_W       = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [31:0]      npc,
    input  logic [1:0]       pcsource,
    input  logic             stall,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic             pc_we,
    output logic             ir_we,
    output logic             fetch_valid,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  boot_q, boot_d;
    logic        fault_q, fault_d;

    logic run;
    logic misaligned;
    logic accept;
    logic stall_inc;
    logic redir_inc;

    // Priority inside RUN: halt, then stall, then alignment check, then update.
    assign run        = (state_q == ST_RUN);
    assign misaligned = (npc[1:0] != 2'b00);
    assign accept     = run && !halt && !stall && !misaligned;
    assign stall_inc  = run && !halt && stall;
    assign redir_inc  = accept && (pcsource != PCS_SEQ);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        boot_d  = boot_q;
        fault_d = fault_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (misaligned) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    pc_d = npc;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            boot_q  <= BOOT_INIT;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            boot_q  <= boot_d;
            fault_q <= fault_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .clr_n (resetn),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clock (clock),
        .clr_n (resetn),
        .inc   (redir_inc),
        .cnt   (redirect_cnt)
    );

    assign pc          = pc_q;
    assign pc_we       = accept;
    assign ir_we       = accept;
    assign fetch_valid = accept;
    assign fault       = fault_q;

endmodule
